// File: rtl/pollard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pollard_controller
// Description : Initiator for the modBigNumbers modular-exponentiation engine.
//               Runs a Pollard p-1 factor search. For k = 2..K it requests
//               r = 2^(k!) mod N and computes g = gcd(r-1, N) with a binary
//               (Stein) GCD engine. It reports the first g with 1 < g < N.
// Ports       : clk, reset (async, active high)
//               start/number/log_num/bound    - search launch and operands
//               busy/done/found/factor/timeout - search status and result
//               me_reset/me_start/me_exponent/me_number/me_log_num -> engine
//               me_result/me_done                                  <- engine
// Options     : POLLARD_TIMEOUT_EN enables a watchdog on me_done
//               (TIMEOUT_CYCLES cycles spent in WAIT ends the search).
// Revision    : 1.0 - initial release
// ============================================================================
module pollard_controller #(
    parameter int MAX_K          = 20,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] number,
    input  logic [7:0]  log_num,
    input  logic [4:0]  bound,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [63:0] factor,
    output logic        timeout,
    output logic        me_reset,
    output logic        me_start,
    output logic [63:0] me_exponent,
    output logic [63:0] me_number,
    output logic [7:0]  me_log_num,
    input  logic [63:0] me_result,
    input  logic        me_done
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_chk_n  = 3'd1;
    localparam logic [2:0] c_st_mul    = 3'd2;
    localparam logic [2:0] c_st_issue  = 3'd3;
    localparam logic [2:0] c_st_wait   = 3'd4;
    localparam logic [2:0] c_st_gcd    = 3'd5;
    localparam logic [2:0] c_st_check  = 3'd6;
    localparam logic [2:0] c_st_finish = 3'd7;

    localparam logic [4:0] c_max_k = 5'(MAX_K);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [63:0] r_n;
    logic [7:0]  r_log;
    logic [4:0]  r_klim;
    logic [4:0]  r_k;
    logic [63:0] r_e;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [6:0]  r_shift;
    logic [63:0] r_g;
    logic        r_armed;
    logic        r_found;
    logic [63:0] r_factor;
    logic        r_timeout;
    logic        w_me_accept;
    logic        w_tmo_hit;

    // The first WAIT cycle never accepts me_done: whatever the engine shows
    // there may still belong to the previous request.
    assign w_me_accept = (r_state == c_st_wait) && r_armed && me_done;

`ifdef POLLARD_TIMEOUT_EN
    localparam int c_tcnt_w = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_tcnt_w-1:0] r_tcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcnt <= '0;
        end else if (r_state != c_st_wait) begin
            r_tcnt <= '0;
        end else if (!w_tmo_hit) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    assign w_tmo_hit = (r_state == c_st_wait) && !w_me_accept &&
                       (r_tcnt == c_tcnt_w'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] w_unused_tmo;
    assign w_unused_tmo = TIMEOUT_CYCLES;
    assign w_tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        me_start    = 1'b0;
        me_reset    = reset;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = c_st_chk_n;
                end
            end
            c_st_chk_n: begin
                busy = 1'b1;
                if ((r_n < 64'd3) || !r_n[0] || (r_klim < 5'd2)) begin
                    w_state_nxt = c_st_finish;
                end else begin
                    w_state_nxt = c_st_mul;
                end
            end
            c_st_mul: begin
                busy        = 1'b1;
                w_state_nxt = c_st_issue;
            end
            c_st_issue: begin
                busy        = 1'b1;
                me_reset    = 1'b1;
                me_start    = 1'b1;
                w_state_nxt = c_st_wait;
            end
            c_st_wait: begin
                busy     = 1'b1;
                me_start = 1'b1;
                if (w_me_accept) begin
                    // r of 0 or 1 means the exponent overshot every factor.
                    w_state_nxt = (me_result <= 64'd1) ? c_st_finish : c_st_gcd;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_st_finish;
                end
            end
            c_st_gcd: begin
                busy = 1'b1;
                if (r_a == r_b) begin
                    w_state_nxt = c_st_check;
                end
            end
            c_st_check: begin
                busy = 1'b1;
                if ((r_g == 64'd1) && (r_k < r_klim)) begin
                    w_state_nxt = c_st_mul;
                end else begin
                    w_state_nxt = c_st_finish;
                end
            end
            c_st_finish: begin
                done        = 1'b1;
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n       <= '0;
            r_log     <= '0;
            r_klim    <= '0;
            r_k       <= '0;
            r_e       <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_shift   <= '0;
            r_g       <= '0;
            r_armed   <= 1'b0;
            r_found   <= 1'b0;
            r_factor  <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_n       <= number;
                        r_log     <= log_num;
                        r_klim    <= (bound > c_max_k) ? c_max_k : bound;
                        r_k       <= 5'd2;
                        r_e       <= 64'd1;
                        r_found   <= 1'b0;
                        r_factor  <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                c_st_chk_n: begin
                    if ((r_n >= 64'd3) && !r_n[0]) begin
                        r_found  <= 1'b1;
                        r_factor <= 64'd2;
                    end
                end
                c_st_mul: begin
                    // k <= 20 keeps k! within 64 bits, so truncation never bites.
                    r_e <= r_e * 64'(r_k);
                end
                c_st_issue: begin
                    r_armed <= 1'b0;
                end
                c_st_wait: begin
                    r_armed <= 1'b1;
                    if (w_me_accept && (me_result > 64'd1)) begin
                        r_a     <= me_result - 64'd1;
                        r_b     <= r_n;
                        r_shift <= '0;
                    end
                    if (w_tmo_hit) begin
                        r_timeout <= 1'b1;
                    end
                end
                c_st_gcd: begin
                    // Stein: one shift or one subtraction per cycle.
                    if (r_a == r_b) begin
                        r_g <= r_a << r_shift;
                    end else if (!r_a[0] && !r_b[0]) begin
                        r_a     <= r_a >> 1;
                        r_b     <= r_b >> 1;
                        r_shift <= r_shift + 7'd1;
                    end else if (!r_a[0]) begin
                        r_a <= r_a >> 1;
                    end else if (!r_b[0]) begin
                        r_b <= r_b >> 1;
                    end else if (r_a > r_b) begin
                        r_a <= r_a - r_b;
                    end else begin
                        r_b <= r_b - r_a;
                    end
                end
                c_st_check: begin
                    if ((r_g > 64'd1) && (r_g < r_n)) begin
                        r_found  <= 1'b1;
                        r_factor <= r_g;
                    end else if ((r_g == 64'd1) && (r_k < r_klim)) begin
                        r_k <= r_k + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign found       = r_found;
    assign factor      = r_factor;
    assign timeout     = r_timeout;
    assign me_exponent = r_e;
    assign me_number   = r_n;
    assign me_log_num  = r_log;

endmodule
`default_nettype wire
